// File: rtl/dut_scan_counter.sv
// ----------------------------------------------------------------------------
// dut_scan_counter
//
// X/Y scan counter that answers the engine's start/enable/near_end handshake.
// X counts pixels along a row, Y counts rows along a frame. Each axis raises
// near_end_* a programmable number of steps before its last position so the
// engine can issue the next start without a bubble cycle.
//
// Handshake (both axes):
//   enable_* qualifies everything on that axis. start_* is only meaningful
//   with enable_* high; start_* && enable_* latches the length, restarts the
//   position at 0 and enters RUN. The engine watches near_end_* and may
//   re-issue start_* the cycle after it appears. With the default X lead of 1,
//   this makes x_pos go from its last pixel straight back to 0. Handshake
//   violations are reported as a one-cycle pulse on protocol_err and cause no
//   counting.
//
// Ports:
//   clk, rst              rising-edge clock, asynchronous active-high reset
//   start_x, enable_x     X restart / X run qualifier (enable_x low = X idle)
//   start_y, enable_y     Y restart / per-row advance pulse
//   x_len, y_len          row length / frame height, sampled on start (0 -> 1)
//   x_pos, y_pos          current pixel / row index
//   near_end_x/_y         axis is within its lead of the last position
//   x_busy, y_busy        axis is in RUN
//   protocol_err          one-cycle pulse after an illegal handshake
//   x_state_dbg/_y        raw FSM state of each axis (0 IDLE, 1 RUN, 2 DONE)
//
// All outputs come straight from flops; there is no input->output path.
// ----------------------------------------------------------------------------
module dut_scan_counter #(
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int X_NEAR_LEAD = 1,
    parameter int Y_NEAR_LEAD = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_x,
    input  logic               enable_x,
    output logic               near_end_x,
    input  logic               start_y,
    input  logic               enable_y,
    output logic               near_end_y,
    input  logic [X_WIDTH-1:0] x_len,
    input  logic [Y_WIDTH-1:0] y_len,
    output logic [X_WIDTH-1:0] x_pos,
    output logic [Y_WIDTH-1:0] y_pos,
    output logic               x_busy,
    output logic               y_busy,
    output logic               protocol_err,
    output logic [1:0]         x_state_dbg,
    output logic [1:0]         y_state_dbg
);

    typedef enum logic [1:0] {
        AX_IDLE = 2'd0,
        AX_RUN  = 2'd1,
        AX_DONE = 2'd2
    } axis_state_e;

    localparam logic [X_WIDTH-1:0] X_ONE  = X_WIDTH'(1);
    localparam logic [Y_WIDTH-1:0] Y_ONE  = Y_WIDTH'(1);
    localparam logic [X_WIDTH-1:0] X_LEAD = X_WIDTH'(X_NEAR_LEAD);
    localparam logic [Y_WIDTH-1:0] Y_LEAD = Y_WIDTH'(Y_NEAR_LEAD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    axis_state_e        x_state_q, x_state_d;
    logic [X_WIDTH-1:0] x_pos_q, x_pos_d;
    logic [X_WIDTH-1:0] x_len_q, x_len_d;      // latched Lx (min 1 once started)
    logic               near_end_x_q, near_end_x_d;

    axis_state_e        y_state_q, y_state_d;
    logic [Y_WIDTH-1:0] y_pos_q, y_pos_d;
    logic [Y_WIDTH-1:0] y_len_q, y_len_d;      // latched Ly (min 1 once started)
    logic               near_end_y_q, near_end_y_d;

    logic               enable_x_prev_q, enable_x_prev_d;
    logic               protocol_err_q, protocol_err_d;

    // Last index and near-end trigger index, derived from the next-cycle length
    // so near_end_* is registered together with the position it refers to.
    logic [X_WIDTH-1:0] x_last_q, x_last_d, x_near_d;
    logic [Y_WIDTH-1:0] y_last_q, y_last_d, y_near_d;

    assign x_last_q = x_len_q - X_ONE;
    assign y_last_q = y_len_q - Y_ONE;

    // ------------------------------------------------------------------
    // X axis
    // ------------------------------------------------------------------
    always_comb begin
        x_state_d    = x_state_q;
        x_pos_d      = x_pos_q;
        x_len_d      = x_len_q;
        x_last_d     = '0;
        x_near_d     = '0;
        near_end_x_d = 1'b0;

        if (!enable_x) begin
            x_state_d = AX_IDLE;
            x_pos_d   = '0;
        end else if (start_x) begin
            // Start wins over count, including from RUN (back-to-back rows).
            x_len_d   = (x_len == '0) ? X_ONE : x_len;
            x_pos_d   = '0;
            x_state_d = AX_RUN;
        end else begin
            case (x_state_q)
                AX_RUN: begin
                    // The last pixel is shown for one RUN cycle, then DONE holds it.
                    if (x_pos_q == x_last_q) begin
                        x_state_d = AX_DONE;
                    end else begin
                        x_pos_d = x_pos_q + X_ONE;
                    end
                end
                default: ;  // IDLE waits for start, DONE holds Lx-1
            endcase
        end

        // Rows shorter than the lead flag near_end on their first pixel.
        x_last_d = x_len_d - X_ONE;
        x_near_d = (x_last_d <= X_LEAD) ? '0 : (x_last_d - X_LEAD);
        near_end_x_d = (x_state_d == AX_RUN) && (x_pos_d == x_near_d);
    end

    // ------------------------------------------------------------------
    // Y axis
    // ------------------------------------------------------------------
    always_comb begin
        y_state_d       = y_state_q;
        y_pos_d         = y_pos_q;
        y_len_d         = y_len_q;
        y_last_d        = '0;
        y_near_d        = '0;
        near_end_y_d    = 1'b0;
        enable_x_prev_d = enable_x;

        if (enable_y && start_y) begin
            y_len_d   = (y_len == '0) ? Y_ONE : y_len;
            y_pos_d   = '0;
            y_state_d = AX_RUN;
        end else if ((y_state_q == AX_DONE) && enable_x_prev_q && !enable_x) begin
            // Frame end: the engine dropping enable_x after the last row
            // releases Y back to IDLE. Y never idles on enable_y alone.
            y_state_d = AX_IDLE;
            y_pos_d   = '0;
        end else if (enable_y && (y_state_q == AX_RUN)) begin
            if (y_pos_q == y_last_q) begin
                y_state_d = AX_DONE;
            end else begin
                y_pos_d = y_pos_q + Y_ONE;
            end
        end

        y_last_d = y_len_d - Y_ONE;
        y_near_d = (y_last_d <= Y_LEAD) ? '0 : (y_last_d - Y_LEAD);
        // Held through DONE so the engine's combined near_end test still fires.
        near_end_y_d = ((y_state_d == AX_RUN) && (y_pos_d == y_near_d)) ||
                       (y_state_d == AX_DONE);
    end

    // ------------------------------------------------------------------
    // Handshake violations
    // ------------------------------------------------------------------
    always_comb begin
        protocol_err_d = (start_x && !enable_x) ||
                         (start_y && !enable_y) ||
                         (enable_y && !start_y && (y_state_q != AX_RUN));
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_state_q       <= AX_IDLE;
            x_pos_q         <= '0;
            x_len_q         <= '0;
            near_end_x_q    <= 1'b0;
            y_state_q       <= AX_IDLE;
            y_pos_q         <= '0;
            y_len_q         <= '0;
            near_end_y_q    <= 1'b0;
            enable_x_prev_q <= 1'b0;
            protocol_err_q  <= 1'b0;
        end else begin
            x_state_q       <= x_state_d;
            x_pos_q         <= x_pos_d;
            x_len_q         <= x_len_d;
            near_end_x_q    <= near_end_x_d;
            y_state_q       <= y_state_d;
            y_pos_q         <= y_pos_d;
            y_len_q         <= y_len_d;
            near_end_y_q    <= near_end_y_d;
            enable_x_prev_q <= enable_x_prev_d;
            protocol_err_q  <= protocol_err_d;
        end
    end

    assign x_pos        = x_pos_q;
    assign y_pos        = y_pos_q;
    assign near_end_x   = near_end_x_q;
    assign near_end_y   = near_end_y_q;
    assign x_busy       = (x_state_q == AX_RUN);
    assign y_busy       = (y_state_q == AX_RUN);
    assign protocol_err = protocol_err_q;
    assign x_state_dbg  = x_state_q;
    assign y_state_dbg  = y_state_q;

endmodule
